// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of two-wide fetch bundles between fetch and decode.
// Ports: CLK/reset, flush, enq_* (bundle in, valid/ready), deq_* (head bundle out), fq_count.
module fetch_queue #(
    parameter int XLEN        = 32,
    parameter int PHT_ADDRESS = 9,
    parameter int DEPTH       = 8
) (
    input  logic                   CLK,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   enq_valid,
    output logic                   enq_ready,
    input  logic [XLEN-1:0]        enq_pc,
    input  logic [31:0]            enq_instr1,
    input  logic [31:0]            enq_instr2,
    input  logic                   enq_slot2_valid,
    input  logic                   enq_pred_taken1,
    input  logic                   enq_pred_taken2,
    input  logic [XLEN-1:0]        enq_pred_target1,
    input  logic [XLEN-1:0]        enq_pred_target2,
    input  logic [PHT_ADDRESS-1:0] enq_pht_index1,
    input  logic [PHT_ADDRESS-1:0] enq_pht_index2,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [XLEN-1:0]        deq_pc1,
    output logic [XLEN-1:0]        deq_pc2,
    output logic [31:0]            deq_instr1,
    output logic [31:0]            deq_instr2,
    output logic                   deq_slot2_valid,
    output logic                   deq_pred_taken1,
    output logic                   deq_pred_taken2,
    output logic [XLEN-1:0]        deq_pred_target1,
    output logic [XLEN-1:0]        deq_pred_target2,
    output logic [PHT_ADDRESS-1:0] deq_pht_index1,
    output logic [PHT_ADDRESS-1:0] deq_pht_index2,
    output logic [$clog2(DEPTH):0] fq_count
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW:0]     PTR_ONE = 1;
    localparam logic [XLEN-1:0] PC_STEP = 4;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [31:0]            instr1;
        logic [31:0]            instr2;
        logic                   slot2_valid;
        logic                   taken1;
        logic                   taken2;
        logic [XLEN-1:0]        target1;
        logic [XLEN-1:0]        target2;
        logic [PHT_ADDRESS-1:0] pht1;
        logic [PHT_ADDRESS-1:0] pht2;
    } entry_t;

    entry_t     mem [DEPTH];
    entry_t     wr_entry;
    entry_t     head_entry;
    logic [IW:0] head;
    logic [IW:0] tail;
    logic        empty;
    logic        full;
    logic        enq_fire;
    logic        deq_fire;
    logic        slot2_live;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign empty = (head == tail);
    assign full  = (head[IW-1:0] == tail[IW-1:0]) && (head[IW] != tail[IW]);

    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign fq_count  = tail - head;

    assign enq_fire = enq_valid && enq_ready && !flush;
    assign deq_fire = deq_valid && deq_ready && !flush;

    // A taken slot 1 redirects fetch, so slot 2 is dead.
    assign slot2_live = enq_slot2_valid && !enq_pred_taken1;

    always_comb begin
        wr_entry             = '0;
        wr_entry.pc          = enq_pc;
        wr_entry.instr1      = enq_instr1;
        wr_entry.instr2      = enq_instr2;
        wr_entry.slot2_valid = slot2_live;
        wr_entry.taken1      = enq_pred_taken1;
        wr_entry.taken2      = enq_pred_taken2 && slot2_live;
        wr_entry.target1     = enq_pred_target1;
        wr_entry.target2     = enq_pred_target2;
        wr_entry.pht1        = enq_pht_index1;
        wr_entry.pht2        = enq_pht_index2;
    end

    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq_fire) tail <= tail + PTR_ONE;
            if (deq_fire) head <= head + PTR_ONE;
        end
    end

    // Storage is not reset; occupancy is tracked only by the pointers.
    always_ff @(posedge CLK) begin
        if (enq_fire && !reset) mem[tail[IW-1:0]] <= wr_entry;
    end

    assign head_entry = mem[head[IW-1:0]];

    // Data outputs read as zero whenever nothing is presented.
    always_comb begin
        deq_pc1          = '0;
        deq_pc2          = '0;
        deq_instr1       = '0;
        deq_instr2       = '0;
        deq_slot2_valid  = 1'b0;
        deq_pred_taken1  = 1'b0;
        deq_pred_taken2  = 1'b0;
        deq_pred_target1 = '0;
        deq_pred_target2 = '0;
        deq_pht_index1   = '0;
        deq_pht_index2   = '0;
        if (deq_valid) begin
            deq_pc1          = head_entry.pc;
            deq_pc2          = head_entry.pc + PC_STEP;
            deq_instr1       = head_entry.instr1;
            deq_instr2       = head_entry.instr2;
            deq_slot2_valid  = head_entry.slot2_valid;
            deq_pred_taken1  = head_entry.taken1;
            deq_pred_taken2  = head_entry.taken2;
            deq_pred_target1 = head_entry.target1;
            deq_pred_target2 = head_entry.target2;
            deq_pht_index1   = head_entry.pht1;
            deq_pht_index2   = head_entry.pht2;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch_queue ordering, full/empty, kill, flush, reset.
// Ports: none; drives all fetch_queue inputs and compares outputs against fixed values.
module tb_fetch_queue;

    logic        CLK = 1'b0;
    logic        reset;
    logic        flush;
    logic        enq_valid;
    logic        enq_ready;
    logic [31:0] enq_pc;
    logic [31:0] enq_instr1;
    logic [31:0] enq_instr2;
    logic        enq_slot2_valid;
    logic        enq_pred_taken1;
    logic        enq_pred_taken2;
    logic [31:0] enq_pred_target1;
    logic [31:0] enq_pred_target2;
    logic [8:0]  enq_pht_index1;
    logic [8:0]  enq_pht_index2;
    logic        deq_valid;
    logic        deq_ready;
    logic [31:0] deq_pc1;
    logic [31:0] deq_pc2;
    logic [31:0] deq_instr1;
    logic [31:0] deq_instr2;
    logic        deq_slot2_valid;
    logic        deq_pred_taken1;
    logic        deq_pred_taken2;
    logic [31:0] deq_pred_target1;
    logic [31:0] deq_pred_target2;
    logic [8:0]  deq_pht_index1;
    logic [8:0]  deq_pht_index2;
    logic [3:0]  fq_count;

    int errors = 0;
    int checks = 0;

    fetch_queue #(.XLEN(32), .PHT_ADDRESS(9), .DEPTH(8)) dut (
        .CLK(CLK), .reset(reset), .flush(flush),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_pc(enq_pc), .enq_instr1(enq_instr1), .enq_instr2(enq_instr2),
        .enq_slot2_valid(enq_slot2_valid),
        .enq_pred_taken1(enq_pred_taken1), .enq_pred_taken2(enq_pred_taken2),
        .enq_pred_target1(enq_pred_target1), .enq_pred_target2(enq_pred_target2),
        .enq_pht_index1(enq_pht_index1), .enq_pht_index2(enq_pht_index2),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_pc1(deq_pc1), .deq_pc2(deq_pc2),
        .deq_instr1(deq_instr1), .deq_instr2(deq_instr2),
        .deq_slot2_valid(deq_slot2_valid),
        .deq_pred_taken1(deq_pred_taken1), .deq_pred_taken2(deq_pred_taken2),
        .deq_pred_target1(deq_pred_target1), .deq_pred_target2(deq_pred_target2),
        .deq_pht_index1(deq_pht_index1), .deq_pht_index2(deq_pht_index2),
        .fq_count(fq_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_enq(input logic [31:0] pc);
        enq_pc           = pc;
        enq_instr1       = pc ^ 32'hA5A5_0000;
        enq_instr2       = pc ^ 32'h5A5A_0000;
        enq_slot2_valid  = 1'b1;
        enq_pred_taken1  = 1'b0;
        enq_pred_taken2  = 1'b0;
        enq_pred_target1 = 32'h0;
        enq_pred_target2 = 32'h0;
        enq_pht_index1   = 9'h0;
        enq_pht_index2   = 9'h0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        set_enq(32'h0);
        step(); step();
        reset = 1'b0;
        check("rst_enq_ready", enq_ready, 1);
        check("rst_deq_valid", deq_valid, 0);
        check("rst_count", fq_count, 0);
        check("rst_pc1", deq_pc1, 0);
        check("rst_pc2", deq_pc2, 0);

        // single bundle, held at head while decode stalls
        set_enq(32'h1000); enq_valid = 1'b1;
        step();
        enq_valid = 1'b0;
        check("one_valid", deq_valid, 1);
        check("one_pc1", deq_pc1, 32'h1000);
        check("one_pc2", deq_pc2, 32'h1004);
        check("one_count", fq_count, 1);
        check("one_slot2", deq_slot2_valid, 1);
        check("one_instr1", deq_instr1, 32'hA5A5_1000);
        step();
        check("hold_pc1", deq_pc1, 32'h1000);
        check("hold_count", fq_count, 1);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check("one_drained", deq_valid, 0);

        // fill to full, drop ninth, drain in order
        for (int i = 0; i < 8; i++) begin
            set_enq(32'h2000 + 32'(i) * 32'h10); enq_valid = 1'b1;
            step();
        end
        check("full_ready", enq_ready, 0);
        check("full_count", fq_count, 8);
        set_enq(32'h3000);
        step();
        enq_valid = 1'b0;
        check("drop_count", fq_count, 8);
        deq_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_pc", deq_pc1, 32'h2000 + 32'(i) * 32'h10);
            step();
            if (i == 0) check("ready_back", enq_ready, 1);
        end
        deq_ready = 1'b0;
        check("drain_empty", deq_valid, 0);
        check("drain_count", fq_count, 0);

        // taken slot 1 kills slot 2
        set_enq(32'h4000);
        enq_pred_taken1  = 1'b1;
        enq_pred_taken2  = 1'b1;
        enq_pred_target1 = 32'hDEAD_0000;
        enq_pht_index1   = 9'h1A5;
        enq_pht_index2   = 9'h033;
        enq_valid = 1'b1;
        step();
        enq_valid = 1'b0;
        check("kill_slot2", deq_slot2_valid, 0);
        check("kill_taken2", deq_pred_taken2, 0);
        check("kill_taken1", deq_pred_taken1, 1);
        check("kill_target1", deq_pred_target1, 32'hDEAD_0000);
        check("kill_pht1", deq_pht_index1, 9'h1A5);
        check("kill_pht2", deq_pht_index2, 9'h033);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;

        // sustained stream, pointers wrap
        enq_valid = 1'b1; deq_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            set_enq(32'h5000 + 32'(k) * 32'h8);
            step();
            check("stream_count", fq_count, 1);
            check("stream_pc", deq_pc1, 32'h5000 + 32'(k) * 32'h8);
        end
        enq_valid = 1'b0;
        step();
        deq_ready = 1'b0;
        check("stream_end", fq_count, 0);

        // flush discards entries and same-cycle enqueue
        for (int i = 0; i < 5; i++) begin
            set_enq(32'h6000 + 32'(i) * 32'h10); enq_valid = 1'b1;
            step();
        end
        check("pre_flush", fq_count, 5);
        set_enq(32'h7770); flush = 1'b1; deq_ready = 1'b1;
        step();
        flush = 1'b0; enq_valid = 1'b0; deq_ready = 1'b0;
        check("flush_count", fq_count, 0);
        check("flush_valid", deq_valid, 0);
        check("flush_ready", enq_ready, 1);
        set_enq(32'h8000); enq_valid = 1'b1;
        step();
        enq_valid = 1'b0;
        check("post_flush_pc", deq_pc1, 32'h8000);
        check("post_flush_cnt", fq_count, 1);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;

        // reset wins over flush and enqueue
        for (int i = 0; i < 3; i++) begin
            set_enq(32'h9000 + 32'(i) * 32'h10); enq_valid = 1'b1;
            step();
        end
        set_enq(32'h9990); reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0; enq_valid = 1'b0;
        check("r2_ready", enq_ready, 1);
        check("r2_valid", deq_valid, 0);
        check("r2_count", fq_count, 0);
        check("r2_pc1", deq_pc1, 0);
        check("r2_instr1", deq_instr1, 0);
        set_enq(32'hA000); enq_valid = 1'b1;
        step();
        enq_valid = 1'b0;
        check("r2_fresh_pc", deq_pc1, 32'hA000);
        check("r2_fresh_cnt", fq_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
